// File: rtl/pc_stack_unit_pkg.sv
// Shared constants, stack control bundle and pointer sizing helper for the
// PIC10 program counter and call/return stack.
package pc_stack_unit_pkg;

   localparam logic [1:0] PC_SEL_STACK = 2'd0;
   localparam logic [1:0] PC_SEL_ALU   = 2'd1;
   localparam logic [1:0] PC_SEL_LIT   = 2'd2;
   localparam logic [1:0] PC_SEL_HOLD  = 2'd3;

   localparam int         PC_WIDTH_DEF     = 9;
   localparam logic [8:0] RESET_VECTOR_DEF = 9'h000;

   typedef struct packed {
      logic load;
      logic push;
      logic pop;
   } stack_ctrl_t;

   // A one-entry stack still needs a 1-bit pointer port.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/pc_stack_unit_call_stack.sv
// Circular return-address stack: entry array, pointer, occupancy count and
// sticky overflow/underflow flags.
module call_stack
   import pc_stack_unit_pkg::*;
#(
   parameter int PC_WIDTH    = PC_WIDTH_DEF,
   parameter int STACK_DEPTH = 2
) (
   input  logic                                clk,
   input  logic                                rst,
   input  stack_ctrl_t                         ctrl,
   input  logic [PC_WIDTH-1:0]                 pc,
   output logic [PC_WIDTH-1:0]                 stack_top,
   output logic [ptr_width(STACK_DEPTH)-1:0]   sp,
   output logic                                stack_overflow,
   output logic                                stack_underflow
);

   localparam int SP_W  = ptr_width(STACK_DEPTH);
   localparam int OCC_W = $clog2(STACK_DEPTH + 1);
   localparam logic [SP_W-1:0]  SP_LAST  = SP_W'(STACK_DEPTH - 1);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(STACK_DEPTH);

   logic [PC_WIDTH-1:0] mem [STACK_DEPTH];
   logic [OCC_W-1:0]    occ;
   logic [SP_W-1:0]     sp_up;
   logic [SP_W-1:0]     sp_dn;
   logic                push_only;
   logic                pop_only;

   // Simultaneous push and pop cancel: pointer, occupancy and flags untouched.
   assign push_only = ctrl.push & ~ctrl.pop;
   assign pop_only  = ctrl.pop  & ~ctrl.push;

   // Explicit wrap keeps the pointer legal for non power-of-two depths.
   assign sp_up = (sp == SP_LAST) ? '0 : sp + SP_W'(1);
   assign sp_dn = (sp == '0) ? SP_LAST : sp - SP_W'(1);

   assign stack_top = mem[sp];

   always_ff @(posedge clk) begin
      if (rst) begin
         sp              <= '0;
         occ             <= '0;
         stack_overflow  <= 1'b0;
         stack_underflow <= 1'b0;
         for (int i = 0; i < STACK_DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (ctrl.load)
            mem[sp] <= pc;
         if (push_only) begin
            sp <= sp_up;
            if (occ == OCC_FULL)
               stack_overflow <= 1'b1;
            else
               occ <= occ + OCC_W'(1);
         end else if (pop_only) begin
            // The pointer still retreats on underflow, mirroring PIC wrap.
            sp <= sp_dn;
            if (occ == '0)
               stack_underflow <= 1'b1;
            else
               occ <= occ - OCC_W'(1);
         end
      end
   end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter, PC source mux and skip/squash register for the PIC10 core;
// the return-address stack lives in call_stack.
module pc_stack_unit
   import pc_stack_unit_pkg::*;
#(
   parameter int                  PC_WIDTH     = PC_WIDTH_DEF,
   parameter int                  STACK_DEPTH  = 2,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEF)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [1:0]                          pc_mux_select,
   input  logic                                load_pc,
   input  logic                                inc_pc,
   input  logic                                load_stack,
   input  logic                                inc_stack,
   input  logic                                dec_stack,
   input  logic                                skip_next_instruction,
   input  logic [7:0]                          alu_result,
   input  logic [8:0]                          instruction_literal,
   output logic [PC_WIDTH-1:0]                 pc,
   output logic [7:0]                          pcl,
   output logic [PC_WIDTH-1:0]                 stack_top,
   output logic [ptr_width(STACK_DEPTH)-1:0]   sp,
   output logic                                stack_overflow,
   output logic                                stack_underflow,
   output logic                                squash
);

   logic [PC_WIDTH-1:0] pc_next;
   stack_ctrl_t         stack_ctrl;

   assign stack_ctrl = '{load: load_stack, push: inc_stack, pop: dec_stack};
   assign pcl        = pc[7:0];

   // ALU source is zero-extended: CALL and PCL writes cannot reach the upper page.
   always_comb begin
      pc_next = pc;
      if (load_pc) begin
         case (pc_mux_select)
            PC_SEL_STACK: pc_next = stack_top;
            PC_SEL_ALU:   pc_next = PC_WIDTH'(alu_result);
            PC_SEL_LIT:   pc_next = PC_WIDTH'(instruction_literal);
            PC_SEL_HOLD:  pc_next = pc;
         endcase
      end else if (inc_pc) begin
         pc_next = pc + PC_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc     <= RESET_VECTOR;
         squash <= 1'b0;
      end else begin
         pc     <= pc_next;
         squash <= skip_next_instruction;
      end
   end

   call_stack #(
      .PC_WIDTH    (PC_WIDTH),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_call_stack (
      .clk             (clk),
      .rst             (rst),
      .ctrl            (stack_ctrl),
      .pc              (pc),
      .stack_top       (stack_top),
      .sp              (sp),
      .stack_overflow  (stack_overflow),
      .stack_underflow (stack_underflow)
   );

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed scenarios with literal
// expectations plus randomized strobes checked against a behavioural model.
module tb_pc_stack_unit;

   localparam int PCW   = 9;
   localparam int DEPTH = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] pc_mux_select;
   logic       load_pc, inc_pc, load_stack, inc_stack, dec_stack, skip_next_instruction;
   logic [7:0] alu_result;
   logic [8:0] instruction_literal;
   logic [PCW-1:0] pc, stack_top;
   logic [7:0] pcl;
   logic [0:0] sp;
   logic       stack_overflow, stack_underflow, squash;

   always #5 clk = ~clk;

   pc_stack_unit #(.PC_WIDTH(PCW), .STACK_DEPTH(DEPTH), .RESET_VECTOR(9'h000)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .pc_mux_select         (pc_mux_select),
      .load_pc               (load_pc),
      .inc_pc                (inc_pc),
      .load_stack            (load_stack),
      .inc_stack             (inc_stack),
      .dec_stack             (dec_stack),
      .skip_next_instruction (skip_next_instruction),
      .alu_result            (alu_result),
      .instruction_literal   (instruction_literal),
      .pc                    (pc),
      .pcl                   (pcl),
      .stack_top             (stack_top),
      .sp                    (sp),
      .stack_overflow        (stack_overflow),
      .stack_underflow       (stack_underflow),
      .squash                (squash)
   );

   // Behavioural model: PC as an integer, stack as an array with a circular
   // index and an occupancy count.
   int m_pc, m_sp, m_occ;
   int m_mem [DEPTH];
   bit m_ovf, m_unf, m_squash;
   bit started = 1'b0;
   int compared = 0;
   int mismatched = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_update();
      int npc;
      if (rst) begin
         m_pc = 0; m_sp = 0; m_occ = 0; m_ovf = 0; m_unf = 0; m_squash = 0;
         for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
         started = 1'b1;
         return;
      end
      npc = m_pc;
      if (load_pc) begin
         case (pc_mux_select)
            2'd0: npc = m_mem[m_sp];
            2'd1: npc = int'(alu_result);
            2'd2: npc = int'(instruction_literal);
            default: npc = m_pc;
         endcase
      end else if (inc_pc) begin
         npc = (m_pc + 1) % 512;
      end
      if (load_stack) m_mem[m_sp] = m_pc;
      if (inc_stack && !dec_stack) begin
         if (m_occ == DEPTH) m_ovf = 1; else m_occ++;
         m_sp = (m_sp + 1) % DEPTH;
      end else if (dec_stack && !inc_stack) begin
         if (m_occ == 0) m_unf = 1; else m_occ--;
         m_sp = (m_sp + DEPTH - 1) % DEPTH;
      end
      m_squash = skip_next_instruction;
      m_pc = npc;
   endtask

   // One clock: compare current outputs with the model, advance the model
   // with the inputs about to be sampled, then return just after the edge.
   task automatic step();
      @(negedge clk);
      if (started) begin
         chk("pc", 32'(pc), 32'(m_pc));
         chk("pcl", 32'(pcl), 32'(m_pc % 256));
         chk("stack_top", 32'(stack_top), 32'(m_mem[m_sp]));
         chk("sp", 32'(sp), 32'(m_sp));
         chk("stack_overflow", 32'(stack_overflow), 32'(m_ovf));
         chk("stack_underflow", 32'(stack_underflow), 32'(m_unf));
         chk("squash", 32'(squash), 32'(m_squash));
      end
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 0; pc_mux_select = 2'd3; load_pc = 0; inc_pc = 0; load_stack = 0;
      inc_stack = 0; dec_stack = 0; skip_next_instruction = 0;
      alu_result = 8'h00; instruction_literal = 9'h000;
   endtask

   task automatic do_reset();
      idle(); rst = 1; step(); rst = 0;
   endtask

   task automatic goto_lit(input logic [8:0] lit);
      idle(); load_pc = 1; pc_mux_select = 2'd2; instruction_literal = lit; step();
   endtask

   task automatic do_call(input logic [7:0] target);
      idle(); load_pc = 1; pc_mux_select = 2'd1; alu_result = target; load_stack = 1; step();
      idle(); inc_stack = 1; inc_pc = 1; step();
   endtask

   task automatic do_retlw();
      idle(); dec_stack = 1; step();
      idle(); load_pc = 1; pc_mux_select = 2'd0; step();
   endtask

   initial begin
      idle();
      do_reset();
      chk("reset_pc", 32'(pc), 32'h000);
      chk("reset_sp", 32'(sp), 32'h0);
      chk("reset_flags", 32'({stack_overflow, stack_underflow, squash}), 32'h0);

      // Three increments from reset.
      for (int i = 0; i < 3; i++) begin idle(); inc_pc = 1; step(); end
      chk("inc3_pc", 32'(pc), 32'h003);
      chk("inc3_pcl", 32'(pcl), 32'h03);
      chk("inc3_sp", 32'(sp), 32'h0);

      // Wrap from the top of program space.
      goto_lit(9'h1FF);
      chk("goto_1ff", 32'(pc), 32'h1FF);
      idle(); inc_pc = 1; step();
      chk("wrap_pc", 32'(pc), 32'h000);

      // CALL then RETLW.
      goto_lit(9'h025);
      do_call(8'h80);
      chk("call_pc", 32'(pc), 32'h081);
      chk("call_sp", 32'(sp), 32'h1);
      do_retlw();
      chk("ret_pc", 32'(pc), 32'h025);
      chk("ret_sp", 32'(sp), 32'h0);

      // Three nested calls overflow the 2-deep stack and lose the oldest entry.
      do_reset();
      goto_lit(9'h011); do_call(8'h3F);
      goto_lit(9'h021); do_call(8'h3F);
      chk("ovf_before", 32'(stack_overflow), 32'h0);
      goto_lit(9'h031); do_call(8'h3F);
      chk("nest_pc", 32'(pc), 32'h040);
      chk("ovf_after", 32'(stack_overflow), 32'h1);
      do_retlw();
      chk("ret1_pc", 32'(pc), 32'h031);
      do_retlw();
      chk("ret2_pc", 32'(pc), 32'h021);
      chk("ret2_unf", 32'(stack_underflow), 32'h0);

      // Pop on an empty stack.
      do_reset();
      idle(); dec_stack = 1; step();
      chk("unf_flag", 32'(stack_underflow), 32'h1);
      chk("unf_sp", 32'(sp), 32'h1);
      do_reset();
      chk("unf_clr", 32'(stack_underflow), 32'h0);
      chk("unf_clr_sp", 32'(sp), 32'h0);

      // Skip at cycle 5, reset at cycle 6.
      do_reset();
      for (int c = 1; c <= 4; c++) begin idle(); inc_pc = 1; step(); end
      idle(); inc_pc = 1; skip_next_instruction = 1; step();
      chk("skip_squash", 32'(squash), 32'h1);
      chk("skip_pc", 32'(pc), 32'h005);
      do_reset();
      chk("skip_rst_squash", 32'(squash), 32'h0);
      chk("skip_rst_pc", 32'(pc), 32'h000);

      // Back-to-back skips hold squash, a single idle cycle drops it.
      idle(); skip_next_instruction = 1; step();
      idle(); skip_next_instruction = 1; step();
      chk("skip_b2b", 32'(squash), 32'h1);
      idle(); step();
      chk("skip_drop", 32'(squash), 32'h0);

      // Randomized strobes against the model.
      for (int n = 0; n < 3000; n++) begin
         idle();
         rst                   = ($urandom_range(0, 99) == 0);
         load_pc               = ($urandom_range(0, 3) == 0);
         pc_mux_select         = 2'($urandom_range(0, 3));
         inc_pc                = ($urandom_range(0, 1) == 0);
         load_stack            = ($urandom_range(0, 5) == 0);
         inc_stack             = ($urandom_range(0, 5) == 0);
         dec_stack             = ($urandom_range(0, 5) == 0);
         skip_next_instruction = ($urandom_range(0, 7) == 0);
         alu_result            = 8'($urandom);
         instruction_literal   = 9'($urandom);
         step();
      end
      idle(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
Program counter and 2-level hardware call/return stack for the PIC10-compatible core. It sits directly downstream of the CPU controller and consumes its pc_mux_select, load_pc, inc_pc, load_stack, inc_stack, dec_stack and skip_next_instruction strobes. It drives the program-memory fetch address and the PCL read value. It also produces a one-cycle squash flag that the instruction register uses to replace a skipped instruction with NOP.

Parameters:
PC_WIDTH, 9, program counter width in bits (512-word program space).
STACK_DEPTH, 2, number of return-address entries (PIC10 = 2).
RESET_VECTOR, 9'h000, PC value loaded on reset.

Ports:
clk  input  1  core clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
pc_mux_select  input  2  PC load source: 0 = stack top, 1 = {0, alu_result}, 2 = instruction literal, 3 = hold.
load_pc  input  1  load PC from the selected source.
inc_pc  input  1  PC <= PC + 1.
load_stack  input  1  write the current PC into stack entry [sp].
inc_stack  input  1  push pointer advance.
dec_stack  input  1  pop pointer retreat.
skip_next_instruction  input  1  discard the instruction fetched this cycle.
alu_result  input  8  ALU output, used for CALL targets and PCL writes.
instruction_literal  input  9  instruction_reg_out[8:0], used for the GOTO target.
pc  output  PC_WIDTH  program-memory fetch address.
pcl  output  8  pc[7:0], SFR read value at address 2.
stack_top  output  PC_WIDTH  stack entry [sp], combinational.
sp  output  1  stack pointer (clog2 STACK_DEPTH bits).
stack_overflow  output  1  sticky flag: push issued while the stack holds STACK_DEPTH entries.
stack_underflow  output  1  sticky flag: pop issued while the stack is empty.
squash  output  1  the instruction register currently holds a skipped instruction.

Behaviour:
- Reset (rst high at posedge):
  - pc = RESET_VECTOR; sp = 0; occupancy count = 0.
  - All stack entries = 0; stack_overflow = stack_underflow = squash = 0.
  - rst overrides every other input in the same cycle.
- PC update at posedge, priority order:
  - load_pc set: PC takes the selected source.
    - Select 1 zero-extends alu_result (PC[8] = 0, PIC CALL/PCL semantics).
    - Select 2 takes the 9-bit literal.
    - Select 3 holds PC.
  - Otherwise, inc_pc set: PC <= PC + 1, wrapping from 0x1FF to 0x000.
  - Otherwise: hold.
- Latency: the new pc is visible one posedge after the strobe; pcl always equals pc[7:0].
- Stack, circular and pointer-based:
  - load_stack: mem[sp] <= pc (the pre-update PC, i.e. the return address, since fetch has already incremented it).
  - inc_stack: sp <= sp + 1 mod STACK_DEPTH; occupancy increments, saturating at STACK_DEPTH.
    - inc_stack while occupancy == STACK_DEPTH sets stack_overflow. The oldest entry is overwritten on the next load_stack, matching PIC wrap behaviour.
  - dec_stack: sp <= sp - 1 mod STACK_DEPTH; occupancy decrements, saturating at 0.
    - dec_stack while occupancy == 0 sets stack_underflow. sp still moves.
  - inc_stack and dec_stack together: sp and occupancy unchanged, no flag.
  - load_stack and dec_stack together: the write uses the pre-update sp.
  - stack_top = mem[sp], combinational on the current sp.
- Sequence contracts with the controller:
  - CALL: cycle N has load_pc (select 1) and load_stack. Cycle N+1 has inc_stack and inc_pc.
  - RETLW: cycle N has dec_stack. Cycle N+1 has load_pc (select 0), so PC receives stack_top after the pointer retreat.
- Skip:
  - squash <= skip_next_instruction at each posedge, i.e. high for exactly one cycle per skip strobe.
  - Back-to-back skip strobes keep squash high.
  - squash does not alter the PC; normal inc_pc advances past the squashed word.
- Flags: stack_overflow and stack_underflow are cleared only by rst.

Decomposition:
- Shared constants in definition.vh:
  - PC_SEL_STACK = 2'd0, PC_SEL_ALU = 2'd1, PC_SEL_LIT = 2'd2, PC_SEL_HOLD = 2'd3.
  - PC_WIDTH default and RESET_VECTOR.
- Natural sub-module: call_stack, which holds the entry array, sp, occupancy, flags and stack_top.
- pc_stack_unit holds the PC register, source mux and squash register.

Test Plan:
- Reset then 3 cycles of inc_pc -> pc = 0x003, pcl = 0x03, sp = 0, all flags 0.
- PC wrap: load_pc, select 2, literal 0x1FF; next cycle inc_pc -> pc = 0x000.
- CALL then RETLW:
  - pc = 0x025, then load_pc (select 1, alu_result = 0x80) with load_stack; next cycle inc_stack + inc_pc -> pc = 0x081, sp = 1.
  - Then dec_stack; then load_pc (select 0) -> pc = 0x025.
- Three nested CALLs from pc = 0x010, 0x020, 0x030 (each ending at 0x040) -> stack_overflow = 1 after the third inc_stack. Two RETLWs then return 0x031 then 0x021; the oldest entry is lost.
- dec_stack with an empty stack -> stack_underflow = 1, sp = 1. A subsequent rst clears the flag and sp.
- skip_next_instruction pulsed at cycle 5 -> squash = 1 only in cycle 6; pc advances normally. Mid-sequence rst at cycle 6 -> squash = 0 and pc = 0x000 next cycle.
